// File: rtl/complex_axpy_chunk_feeder.sv
// Chunk feeder for the 8-lane complex axpy unit: streams x/y chunks from vector memory,
// zero-pads the tail chunk and tracks downstream latency to align write-back and finish.
module complex_axpy_chunk_feeder #(
    parameter int NOE           = 19,
    parameter int NI            = 8,
    parameter int element_width = 64,
    parameter int ADDR_W        = 8,
    parameter int PIPE_LAT      = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [element_width-1:0]    constant_in,
    input  logic                        op_in,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [element_width*NI-1:0] x_rd_data,
    input  logic [element_width*NI-1:0] y_rd_data,
    output logic [element_width*NI-1:0] first_row_input,
    output logic [element_width*NI-1:0] second_row_input,
    output logic [element_width-1:0]    constant,
    output logic                        op,
    output logic                        out_valid,
    output logic                        wb_valid,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic                        busy,
    output logic                        finish,
    output logic [1:0]                  dbg_state
);

    localparam int C     = (NOE + NI - 1) / NI;
    localparam int V     = NOE - (C - 1) * NI;
    localparam int BUS_W = element_width * NI;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(C - 1);

    // Handshake: no backpressure. rd_en/rd_addr request a chunk whose data arrives one
    // cycle later; out_valid marks a registered chunk; wb_valid is out_valid delayed PIPE_LAT.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [element_width-1:0]  const_q, const_d;
    logic                      op_q, op_d;
    logic                      rd_vld_q;
    logic [ADDR_W-1:0]         rd_idx_q;
    logic                      ov_q;
    logic [ADDR_W-1:0]         ov_idx_q;
    logic [BUS_W-1:0]          x_q, y_q, x_d, y_d, lane_mask;
    logic [PIPE_LAT-1:0]       dl_vld_q;
    logic [ADDR_W-1:0]         dl_idx_q [PIPE_LAT];
    logic                      start_ok;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        const_d = const_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    const_d = constant_in;
                    op_d    = op_in;
                end
            end
            S_READ: begin
                if (addr_q == LAST) state_d = S_DRAIN;
                else                addr_d  = addr_q + ADDR_W'(1);
            end
            S_DRAIN: begin
                // Leave once the last chunk's write-back slot has been presented.
                if (dl_vld_q[PIPE_LAT-1] && dl_idx_q[PIPE_LAT-1] == LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane_mask = '0;
        for (int j = 0; j < NI; j++) begin
            if (!(rd_idx_q == LAST && j >= V))
                lane_mask[element_width*(NI-j)-1 -: element_width] = '1;
        end
        x_d = x_rd_data & lane_mask;
        y_d = y_rd_data & lane_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            const_q  <= '0;
            op_q     <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            ov_q     <= 1'b0;
            ov_idx_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dl_vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) dl_idx_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            const_q  <= const_d;
            op_q     <= op_d;
            rd_vld_q <= (state_q == S_READ);
            rd_idx_q <= addr_q;
            ov_q     <= rd_vld_q;
            if (rd_vld_q) begin
                ov_idx_q <= rd_idx_q;
                x_q      <= x_d;
                y_q      <= y_d;
            end
            dl_vld_q[0] <= ov_q;
            dl_idx_q[0] <= ov_idx_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
        end
    end

    assign rd_en            = (state_q == S_READ);
    assign rd_addr          = addr_q;
    assign first_row_input  = x_q;
    assign second_row_input = y_q;
    assign constant         = const_q;
    assign op               = op_q;
    assign out_valid        = ov_q;
    assign wb_valid         = dl_vld_q[PIPE_LAT-1];
    assign wb_addr          = dl_idx_q[PIPE_LAT-1];
    assign busy             = (state_q == S_READ) || (state_q == S_DRAIN);
    assign finish           = (state_q == S_DONE);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_complex_axpy_chunk_feeder.sv
// Directed bench for complex_axpy_chunk_feeder: three instances (NOE 19, 16, 5) with
// behavioural vector memories; every output checked cycle by cycle against the timing plan.
module tb_complex_axpy_chunk_feeder;

    localparam int P = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [63:0] constant_in = '0;
    logic op_in = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic rd_en_a, rd_en_b, rd_en_c;
    logic [7:0] rd_addr_a, rd_addr_b, rd_addr_c;
    logic [511:0] x_rd_a = '0, y_rd_a = '0, x_rd_b = '0, y_rd_b = '0, x_rd_c = '0, y_rd_c = '0;
    logic [511:0] fri_a, sri_a, fri_b, sri_b, fri_c, sri_c;
    logic [63:0] const_a, const_b, const_c;
    logic op_a, op_b, op_c, ov_a, ov_b, ov_c, wbv_a, wbv_b, wbv_c;
    logic [7:0] wba_a, wba_b, wba_c;
    logic busy_a, busy_b, busy_c, fin_a, fin_b, fin_c;
    logic [1:0] st_a, st_b, st_c;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    complex_axpy_chunk_feeder #(.NOE(19), .NI(8), .element_width(64), .ADDR_W(8), .PIPE_LAT(P)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .constant_in(constant_in), .op_in(op_in),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .x_rd_data(x_rd_a), .y_rd_data(y_rd_a),
        .first_row_input(fri_a), .second_row_input(sri_a), .constant(const_a), .op(op_a),
        .out_valid(ov_a), .wb_valid(wbv_a), .wb_addr(wba_a), .busy(busy_a), .finish(fin_a),
        .dbg_state(st_a));

    complex_axpy_chunk_feeder #(.NOE(16), .NI(8), .element_width(64), .ADDR_W(8), .PIPE_LAT(P)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .constant_in(constant_in), .op_in(op_in),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .x_rd_data(x_rd_b), .y_rd_data(y_rd_b),
        .first_row_input(fri_b), .second_row_input(sri_b), .constant(const_b), .op(op_b),
        .out_valid(ov_b), .wb_valid(wbv_b), .wb_addr(wba_b), .busy(busy_b), .finish(fin_b),
        .dbg_state(st_b));

    complex_axpy_chunk_feeder #(.NOE(5), .NI(8), .element_width(64), .ADDR_W(8), .PIPE_LAT(P)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .constant_in(constant_in), .op_in(op_in),
        .rd_en(rd_en_c), .rd_addr(rd_addr_c), .x_rd_data(x_rd_c), .y_rd_data(y_rd_c),
        .first_row_input(fri_c), .second_row_input(sri_c), .constant(const_c), .op(op_c),
        .out_valid(ov_c), .wb_valid(wbv_c), .wb_addr(wba_c), .busy(busy_c), .finish(fin_c),
        .dbg_state(st_c));

    // Element e of x or y: unique, never zero, so padding is distinguishable from data.
    function automatic logic [63:0] elem(input bit is_y, input int e);
        return {(is_y ? 8'hB0 : 8'hA0), 8'(e), 16'h3f80, 8'hC3, 8'(e), 16'h5a5a};
    endfunction

    function automatic logic [511:0] mem_chunk(input bit is_y, input int k);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[511-64*j -: 64] = elem(is_y, k*8 + j);
        return r;
    endfunction

    function automatic logic [511:0] exp_chunk(input bit is_y, input int k, input int noe);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            if (k*8 + j < noe) r[511-64*j -: 64] = elem(is_y, k*8 + j);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rd_en_a) begin x_rd_a <= mem_chunk(0, int'(rd_addr_a)); y_rd_a <= mem_chunk(1, int'(rd_addr_a)); end
        if (rd_en_b) begin x_rd_b <= mem_chunk(0, int'(rd_addr_b)); y_rd_b <= mem_chunk(1, int'(rd_addr_b)); end
        if (rd_en_c) begin x_rd_c <= mem_chunk(0, int'(rd_addr_c)); y_rd_c <= mem_chunk(1, int'(rd_addr_c)); end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_en_a, rd_addr_a, ov_a, wbv_a, wba_a, busy_a, fin_a, op_a} !== '0 || const_a !== '0
            || fri_a !== '0 || sri_a !== '0) begin
            n_fail++; $display("FAIL reset_a outputs: rd_en=%b addr=%h ov=%b wbv=%b busy=%b fin=%b const=%h op=%b, required all 0",
                               rd_en_a, rd_addr_a, ov_a, wbv_a, busy_a, fin_a, const_a, op_a);
        end
        n_checks++;
        if ({rd_en_b, busy_b, fin_b, ov_b, rd_en_c, busy_c, fin_c, ov_c} !== '0) begin
            n_fail++; $display("FAIL reset_bc outputs nonzero: %b, required 0",
                               {rd_en_b, busy_b, fin_b, ov_b, rd_en_c, busy_c, fin_c, ov_c});
        end
        reset = 1'b0;
    endtask

    // Full NOE=19 run; optionally fires a second start with a different constant during READ.
    task automatic run_a(input string tag, input logic [63:0] cval, input logic opv, input bit extra_start);
        bit e_rd, e_ov, e_wb, e_fin;
        @(negedge clk);
        start_a = 1'b1; constant_in = cval; op_in = opv;
        @(negedge clk);
        start_a = 1'b0; constant_in = ~cval; op_in = ~opv;
        for (int n = 0; n <= 14; n++) begin
            if (n > 0) @(negedge clk);
            if (extra_start && n == 1) begin start_a = 1'b1; constant_in = 64'hDEAD_BEEF_0BAD_F00D; end
            else start_a = 1'b0;
            e_rd = (n < 3); e_ov = (n >= 2 && n < 5); e_wb = (n >= 9 && n < 12); e_fin = (n >= 12);
            n_checks++;
            if (rd_en_a !== e_rd) begin n_fail++; $display("FAIL %s rd_en n=%0d got %b required %b", tag, n, rd_en_a, e_rd); end
            if (e_rd) begin
                n_checks++;
                if (rd_addr_a !== 8'(n)) begin n_fail++; $display("FAIL %s rd_addr n=%0d got %0d required %0d", tag, n, rd_addr_a, n); end
            end
            n_checks++;
            if (ov_a !== e_ov) begin n_fail++; $display("FAIL %s out_valid n=%0d got %b required %b", tag, n, ov_a, e_ov); end
            if (e_ov) begin
                n_checks++;
                if (fri_a !== exp_chunk(0, n-2, 19)) begin n_fail++; $display("FAIL %s first_row n=%0d got %h required %h", tag, n, fri_a, exp_chunk(0, n-2, 19)); end
                n_checks++;
                if (sri_a !== exp_chunk(1, n-2, 19)) begin n_fail++; $display("FAIL %s second_row n=%0d got %h required %h", tag, n, sri_a, exp_chunk(1, n-2, 19)); end
            end
            n_checks++;
            if (wbv_a !== e_wb) begin n_fail++; $display("FAIL %s wb_valid n=%0d got %b required %b", tag, n, wbv_a, e_wb); end
            if (e_wb) begin
                n_checks++;
                if (wba_a !== 8'(n-9)) begin n_fail++; $display("FAIL %s wb_addr n=%0d got %0d required %0d", tag, n, wba_a, n-9); end
            end
            n_checks++;
            if (fin_a !== e_fin) begin n_fail++; $display("FAIL %s finish n=%0d got %b required %b", tag, n, fin_a, e_fin); end
            n_checks++;
            if (busy_a !== !e_fin) begin n_fail++; $display("FAIL %s busy n=%0d got %b required %b", tag, n, busy_a, !e_fin); end
            n_checks++;
            if (const_a !== cval || op_a !== opv) begin
                n_fail++; $display("FAIL %s const/op n=%0d got %h/%b required %h/%b", tag, n, const_a, op_a, cval, opv);
            end
        end
    endtask

    task automatic test_noe19_basic();
        run_a("noe19", 64'h3f800000_00000000, 1'b0, 1'b0);
    endtask

    task automatic test_start_in_done();
        run_a("restart_done_sub", 64'h40000000_bf800000, 1'b1, 1'b0);
    endtask

    task automatic test_start_during_read();
        run_a("start_in_read", 64'h3f000000_3f000000, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        @(negedge clk);
        start_a = 1'b1; constant_in = 64'h41200000_41200000; op_in = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({rd_en_a, rd_addr_a, ov_a, wbv_a, wba_a, busy_a, fin_a, op_a} !== '0 || const_a !== '0
            || fri_a !== '0 || sri_a !== '0) begin
            n_fail++; $display("FAIL async_reset outputs: ov=%b wbv=%b busy=%b fin=%b const=%h op=%b, required all 0",
                               ov_a, wbv_a, busy_a, fin_a, const_a, op_a);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            n_checks++;
            if (fin_a !== 1'b0 || wbv_a !== 1'b0 || rd_en_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_quiet n=%0d fin=%b wbv=%b rd_en=%b busy=%b required 0", n, fin_a, wbv_a, rd_en_a, busy_a);
            end
        end
        run_a("after_reset", 64'h3f800000_00000000, 1'b0, 1'b0);
    endtask

    task automatic test_noe16();
        bit e_rd, e_ov, e_wb, e_fin;
        @(negedge clk);
        start_b = 1'b1; constant_in = 64'h3f800000_3f800000; op_in = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        for (int n = 0; n <= 13; n++) begin
            if (n > 0) @(negedge clk);
            e_rd = (n < 2); e_ov = (n >= 2 && n < 4); e_wb = (n >= 9 && n < 11); e_fin = (n >= 11);
            n_checks++;
            if (rd_en_b !== e_rd || (e_rd && rd_addr_b !== 8'(n))) begin
                n_fail++; $display("FAIL noe16 rd n=%0d got %b/%0d required %b/%0d", n, rd_en_b, rd_addr_b, e_rd, n);
            end
            n_checks++;
            if (ov_b !== e_ov) begin n_fail++; $display("FAIL noe16 out_valid n=%0d got %b required %b", n, ov_b, e_ov); end
            if (e_ov) begin
                n_checks++;
                if (fri_b !== mem_chunk(0, n-2) || sri_b !== mem_chunk(1, n-2)) begin
                    n_fail++; $display("FAIL noe16 lanes n=%0d got %h required %h", n, fri_b, mem_chunk(0, n-2));
                end
            end
            n_checks++;
            if (wbv_b !== e_wb || (e_wb && wba_b !== 8'(n-9))) begin
                n_fail++; $display("FAIL noe16 wb n=%0d got %b/%0d required %b/%0d", n, wbv_b, wba_b, e_wb, n-9);
            end
            n_checks++;
            if (fin_b !== e_fin || busy_b !== !e_fin) begin
                n_fail++; $display("FAIL noe16 finish/busy n=%0d got %b/%b required %b/%b", n, fin_b, busy_b, e_fin, !e_fin);
            end
        end
    endtask

    task automatic test_noe5();
        bit e_rd, e_ov, e_wb, e_fin;
        @(negedge clk);
        start_c = 1'b1; constant_in = 64'hbf800000_00000000; op_in = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int n = 0; n <= 12; n++) begin
            if (n > 0) @(negedge clk);
            e_rd = (n == 0); e_ov = (n == 2); e_wb = (n == 9); e_fin = (n >= 10);
            n_checks++;
            if (rd_en_c !== e_rd || (e_rd && rd_addr_c !== 8'd0)) begin
                n_fail++; $display("FAIL noe5 rd n=%0d got %b/%0d required %b/0", n, rd_en_c, rd_addr_c, e_rd);
            end
            n_checks++;
            if (ov_c !== e_ov) begin n_fail++; $display("FAIL noe5 out_valid n=%0d got %b required %b", n, ov_c, e_ov); end
            if (e_ov) begin
                n_checks++;
                if (fri_c !== exp_chunk(0, 0, 5) || sri_c !== exp_chunk(1, 0, 5)) begin
                    n_fail++; $display("FAIL noe5 lanes got %h required %h", fri_c, exp_chunk(0, 0, 5));
                end
            end
            n_checks++;
            if (wbv_c !== e_wb || (e_wb && wba_c !== 8'd0)) begin
                n_fail++; $display("FAIL noe5 wb n=%0d got %b/%0d required %b/0", n, wbv_c, wba_c, e_wb);
            end
            n_checks++;
            if (fin_c !== e_fin || busy_c !== !e_fin || op_c !== 1'b1) begin
                n_fail++; $display("FAIL noe5 finish/busy/op n=%0d got %b/%b/%b required %b/%b/1", n, fin_c, busy_c, op_c, e_fin, !e_fin);
            end
        end
    endtask

    initial begin
        test_reset();
        test_noe19_basic();
        test_start_in_done();
        test_start_during_read();
        test_reset_mid_drain();
        test_noe16();
        test_noe5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/complex_axpy_chunk_feeder.md
Name: complex_axpy_chunk_feeder

Overview:
- Upstream stage of the 8-lane complex vector-times-constant add/subtract unit.
- Reads two complex vectors (x, y) from dual-read vector memory one NI-element chunk per cycle.
- Zero-pads the final partial chunk, latches constant and op for the whole run, presents aligned lane buses to the downstream unit.
- Tracks downstream pipeline latency so write-back valid/address line up with results; raises finish when the last result is out.

Parameters:
- NOE, 19, number of complex elements per vector.
- NI, 8, lanes per chunk.
- element_width, 64, bits per complex element (upper 32 real, lower 32 imag, IEEE-754 single).
- ADDR_W, 8, chunk address width; must satisfy ceil(NOE/NI) <= 2^ADDR_W.
- PIPE_LAT, 7, cycles from first_row_input/second_row_input valid to result valid in the downstream unit.

Ports:
- clk, in, 1, clock, all logic on rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle request to begin a run; sampled only in IDLE/DONE.
- constant_in, in, element_width, complex scalar, latched on accepted start.
- op_in, in, 1, 0=add, 1=subtract, latched on accepted start.
- rd_en, out, 1, memory read strobe.
- rd_addr, out, ADDR_W, chunk index being read.
- x_rd_data, in, element_width*NI, x chunk, valid the cycle after rd_en.
- y_rd_data, in, element_width*NI, y chunk, valid the cycle after rd_en.
- first_row_input, out, element_width*NI, masked x chunk to downstream.
- second_row_input, out, element_width*NI, masked y chunk to downstream.
- constant, out, element_width, latched scalar.
- op, out, 1, latched op.
- out_valid, out, 1, lane buses hold a valid chunk.
- wb_valid, out, 1, downstream result valid this cycle (out_valid delayed PIPE_LAT).
- wb_addr, out, ADDR_W, chunk index for write-back.
- busy, out, 1, high in READ and DRAIN.
- finish, out, 1, run complete; held until next accepted start or reset.

Behaviour:
- C = ceil(NOE/NI); V = NOE - (C-1)*NI valid lanes in last chunk (19/8: C=3, V=3).
- Lane j (0..NI-1) occupies bits [element_width*(NI-j)-1 -: element_width]; element 0 at MSB.
- Reset (async): state=IDLE; every output 0, including constant and op; delay line cleared.
- States:
  - IDLE: start accepted -> latch constant_in/op_in, clear finish, go to READ.
  - READ: rd_en=1, rd_addr=k for k=0..C-1 on consecutive cycles. After the edge issuing k=C-1 -> DRAIN.
  - DRAIN: wait until last wb_valid has been presented -> DONE.
  - DONE: finish=1; start accepted exactly as in IDLE.
- start is ignored in READ and DRAIN.
- Timing (edge E0 samples start):
  - rd_en/rd_addr=0 valid after E0.
  - Memory data valid after E1.
  - Block registers the masked chunk at E2, so chunk k has out_valid=1 after edge E2+k.
  - wb_valid/wb_addr for chunk k valid after edge E2+k+PIPE_LAT.
  - finish rises at the edge that ends the last wb_valid cycle.
  - busy falls on that same edge.
- Masking: in chunk C-1, lanes j >= V of both first_row_input and second_row_input are forced to 0. If NOE%NI==0, no lanes are masked.
- out_valid=0 cycles: lane buses hold their last value; downstream ignores them.
- Delay line is a PIPE_LAT-deep shift of {out_valid, chunk index}. No backpressure.
- C==1: READ lasts one cycle; the single chunk is both first and last, masking applies.
- Reset mid-run aborts immediately: no further rd_en, wb_valid or finish.

Test Plan:
- NOE=19, NI=8, constant=3f800000_00000000, op=0, start at E0 -> rd_addr 0,1,2 after E0..E2; out_valid after E2..E4; chunk 2 lanes 3..7 zero; wb_addr 0,1,2 after E9..E11; finish=1 after E12, busy=0.
- NOE=16 -> C=2, no lanes masked, finish after E2+2+7=E11.
- Second start pulse during READ, with different constant_in -> ignored; constant unchanged; rd_addr sequence unchanged.
- Reset asserted asynchronously mid-cycle in DRAIN -> all outputs 0 immediately; finish never asserts; next start runs cleanly from rd_addr=0.
- Start in DONE with op_in=1 -> finish clears after the start edge, op=1, full sequence repeats.
- NOE=5 (C=1) -> single rd_en cycle; lanes 5..7 zero; finish after E2+1+7=E10.
